// File: rtl/tank_pump_ctrl_n.sv
// tank_pump_ctrl_n: Moore tank level controller for NUM_PUMPS fill pumps.
// Define STAGGER_START_EN to bring pumps on one at a time in EMPTY.
module tank_pump_ctrl_n #(
  parameter  int NUM_PUMPS   = 2,
  parameter  int MIN_DWELL   = 4,
  parameter  int FAULT_CLEAR = 3,
  parameter  int STAGGER     = 2,
  localparam int PW = (NUM_PUMPS > 2) ? $clog2(NUM_PUMPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 I,
  input  logic                 S,
  output logic [NUM_PUMPS-1:0] B,
  output logic                 fault,
  output logic [1:0]           state,
  output logic [PW-1:0]        ptr
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam int CW = $clog2(FAULT_CLEAR + 1);
  localparam logic [NUM_PUMPS-1:0] ONE = NUM_PUMPS'(1);

  if (NUM_PUMPS < 2 || NUM_PUMPS > 8 || MIN_DWELL < 1 ||
      FAULT_CLEAR < 1 || STAGGER < 0) begin : g_bad_param
    $error("tank_pump_ctrl_n: parameter out of range");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HALF  = 2'b01,
    FAULT = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t               state_q, state_d, tgt;
  logic                 i_q, s_q;
  logic [DW-1:0]        dwell_q, dwell_d;
  logic [CW-1:0]        clr_q, clr_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_PUMPS-1:0] empty_mask;
  logic [NUM_PUMPS-1:0] pumps;

  // Sensor sampling and controller state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q     <= 1'b1;
      s_q     <= 1'b1;
      state_q <= FULL;
      dwell_q <= '0;
      clr_q   <= '0;
      ptr_q   <= '0;
    end else begin
      i_q     <= I;
      s_q     <= S;
      state_q <= state_d;
      dwell_q <= dwell_d;
      clr_q   <= clr_d;
      ptr_q   <= ptr_d;
    end
  end

  // Classify the registered sensor pair into a target level
  always_comb begin
    tgt = FAULT;
    unique case ({i_q, s_q})
      2'b11:   tgt = FULL;
      2'b10:   tgt = HALF;
      2'b00:   tgt = EMPTY;
      default: tgt = FAULT;
    endcase
  end

  // Next state: fault entry first, then timed fault exit or dwell-gated moves
  always_comb begin
    state_d = state_q;
    clr_d   = '0;
    dwell_d = dwell_q;
    ptr_d   = ptr_q;
    if (state_q == FAULT) begin
      if (tgt != FAULT) begin
        if (clr_q == CW'(FAULT_CLEAR - 1)) begin
          state_d = tgt;
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
    end else if (tgt == FAULT) begin
      state_d = FAULT;
    end else if (tgt != state_q && dwell_q == DW'(MIN_DWELL)) begin
      state_d = tgt;
    end
    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (dwell_q != DW'(MIN_DWELL)) begin
      dwell_d = dwell_q + 1'b1;
    end
    if (state_q == HALF && state_d != HALF) begin
      if (ptr_q == PW'(NUM_PUMPS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

`ifdef STAGGER_START_EN
  localparam int SMAX = (NUM_PUMPS - 1) * STAGGER;
  localparam int SW   = (SMAX > 0) ? $clog2(SMAX + 1) : 1;

  logic [SW-1:0] stg_q, stg_d;

  // Stagger timer runs only while EMPTY is held, cleared otherwise
  always_comb begin
    stg_d = '0;
    if (state_q == EMPTY && state_d == EMPTY) begin
      if (stg_q != SW'(SMAX)) begin
        stg_d = stg_q + 1'b1;
      end else begin
        stg_d = stg_q;
      end
    end
  end

  // Stagger timer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  // Pump at ring offset k from ptr turns on after k*STAGGER cycles
  always_comb begin
    int off;
    off        = 0;
    empty_mask = '0;
    for (int i = 0; i < NUM_PUMPS; i++) begin
      off = i - int'(ptr_q);
      if (off < 0) begin
        off = off + NUM_PUMPS;
      end
      empty_mask[i] = (int'(stg_q) >= off * STAGGER);
    end
  end
`else
  assign empty_mask = '1;
`endif

  // Moore output decode from the current state and pointer
  always_comb begin
    pumps = '0;
    unique case (state_q)
      HALF:    pumps = ONE << ptr_q;
      EMPTY:   pumps = empty_mask;
      default: pumps = '0;
    endcase
  end

  assign B     = pumps;
  assign fault = (state_q == FAULT);
  assign state = state_q;
  assign ptr   = ptr_q;

endmodule

// File: tb/tb_tank_pump_ctrl_n.sv
// tb_tank_pump_ctrl_n: randomized and directed bench for tank_pump_ctrl_n.
// Expected outputs come from a level/age model of the controller rules.
module tb_tank_pump_ctrl_n;

  localparam int NP = 3;
  localparam int MD = 4;
  localparam int FC = 3;
  localparam int ST = 2;
  localparam int PW = 2;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          I     = 1'b1;
  logic          S     = 1'b1;
  logic [NP-1:0] B;
  logic          fault;
  logic [1:0]    state;
  logic [PW-1:0] ptr;

  int tests = 0;
  int fails = 0;

  tank_pump_ctrl_n #(
    .NUM_PUMPS  (NP),
    .MIN_DWELL  (MD),
    .FAULT_CLEAR(FC),
    .STAGGER    (ST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .I    (I),
    .S    (S),
    .B    (B),
    .fault(fault),
    .state(state),
    .ptr  (ptr)
  );

  always #5 clk = ~clk;

  typedef enum {LV_FULL, LV_HALF, LV_EMPTY, LV_FAULT} lvl_t;

  lvl_t m_lvl;
  int   m_age;
  int   m_good;
  int   m_ptr;
  bit   m_i;
  bit   m_s;

  function automatic lvl_t classify(input bit i, input bit s);
    if (i && s) return LV_FULL;
    if (i) return LV_HALF;
    if (s) return LV_FAULT;
    return LV_EMPTY;
  endfunction

  function automatic logic [1:0] exp_state();
    case (m_lvl)
      LV_FULL:  return 2'b11;
      LV_HALF:  return 2'b01;
      LV_EMPTY: return 2'b00;
      default:  return 2'b10;
    endcase
  endfunction

  function automatic logic [NP-1:0] exp_b();
    logic [NP-1:0] b;
    int n;
    b = '0;
    n = 0;
    if (m_lvl == LV_HALF) begin
      b = NP'(1) << m_ptr;
    end else if (m_lvl == LV_EMPTY) begin
`ifdef STAGGER_START_EN
      n = m_age / ST + 1;
      if (n > NP) n = NP;
`else
      n = NP;
`endif
      for (int k = 0; k < n; k++) begin
        b = b | (NP'(1) << ((m_ptr + k) % NP));
      end
    end
    return b;
  endfunction

  function automatic logic [NP+PW+2:0] exp_vec();
    return {exp_state(), exp_b(), m_lvl == LV_FAULT, PW'(m_ptr)};
  endfunction

  task automatic model_reset();
    m_lvl  = LV_FULL;
    m_age  = 0;
    m_good = 0;
    m_ptr  = 0;
    m_i    = 1'b1;
    m_s    = 1'b1;
  endtask

  task automatic model_edge();
    lvl_t tgt;
    lvl_t nxt;
    tgt = classify(m_i, m_s);
    nxt = m_lvl;
    if (m_lvl == LV_FAULT) begin
      if (tgt == LV_FAULT) begin
        m_good = 0;
      end else begin
        m_good++;
        if (m_good >= FC) nxt = tgt;
      end
    end else if (tgt == LV_FAULT) begin
      nxt = LV_FAULT;
    end else if (tgt != m_lvl && m_age >= MD) begin
      nxt = tgt;
    end
    if (nxt != m_lvl) begin
      if (m_lvl == LV_HALF) m_ptr = (m_ptr + 1) % NP;
      m_lvl  = nxt;
      m_age  = 0;
      m_good = 0;
    end else begin
      m_age++;
    end
    m_i = I;
    m_s = S;
  endtask

  task automatic drive(input bit i, input bit s);
    @(negedge clk);
    I = i;
    S = s;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    I = 1'b1;
    S = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if ({state, B, fault, ptr} !== 8'b11_000_0_00) begin
        fails++;
        $display("FAIL reset_hold: got st=%b B=%b f=%b p=%0d, want st=11 B=000 f=0 p=0",
                 state, B, fault, ptr);
      end
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 5; t++) begin
      #1;
      tests++;
      if (B !== 3'b000) begin
        fails++;
        $display("FAIL reset_release_glitch: got B=%b, want 000", B);
      end
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL reset_idle c%0d: got {st,B,f,p}=%b, want %b",
                 c, {state, B, fault, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_rotation();
    logic [NP-1:0] want;
    for (int r = 0; r < 4; r++) begin
      want = NP'(1) << (r % NP);
      for (int c = 0; c < 6; c++) begin
        drive(1'b1, 1'b0);
        tests++;
        if ({state, B, fault, ptr} !== exp_vec()) begin
          fails++;
          $display("FAIL rotation_half r%0d c%0d: got {st,B,f,p}=%b, want %b",
                   r, c, {state, B, fault, ptr}, exp_vec());
        end
        if (c == 1) begin
          tests++;
          if (state !== 2'b01 || B !== want) begin
            fails++;
            $display("FAIL rotation_latency r%0d: got st=%b B=%b, want st=01 B=%b",
                     r, state, B, want);
          end
        end
      end
      for (int c = 0; c < 6; c++) begin
        drive(1'b1, 1'b1);
        tests++;
        if ({state, B, fault, ptr} !== exp_vec()) begin
          fails++;
          $display("FAIL rotation_full r%0d c%0d: got {st,B,f,p}=%b, want %b",
                   r, c, {state, B, fault, ptr}, exp_vec());
        end
      end
    end
  endtask

  task automatic test_chatter();
    for (int c = 0; c < 12; c++) begin
      drive(1'b1, (c % 2) == 1);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL chatter c%0d: got {st,B,f,p}=%b, want %b",
                 c, {state, B, fault, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_fault();
    bit [1:0] seq[$];
    seq = {};
    repeat (12) seq.push_back(2'b11);
    repeat (6) seq.push_back(2'b10);
    seq.push_back(2'b01);
    repeat (2) seq.push_back(2'b00);
    seq.push_back(2'b01);
    repeat (6) seq.push_back(2'b00);
    foreach (seq[k]) begin
      drive(seq[k][1], seq[k][0]);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL fault_seq k%0d: got {st,B,f,p}=%b, want %b",
                 k, {state, B, fault, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_stagger();
    repeat (12) begin
      drive(1'b1, 1'b1);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL stagger_settle: got {st,B,f,p}=%b, want %b",
                 {state, B, fault, ptr}, exp_vec());
      end
    end
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL stagger_empty c%0d: got {st,B,f,p}=%b, want %b",
                 c, {state, B, fault, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit ri;
    bit rs;
    ri = 1'b1;
    rs = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        ri = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        if (!ri && rs && $urandom_range(0, 1) == 0) rs = 1'b0;
      end
      drive(ri, rs);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL random c%0d in=%b%b: got {st,B,f,p}=%b, want %b",
                 c, ri, rs, {state, B, fault, ptr}, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    repeat (12) drive(1'b1, 1'b1);
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 1'b0);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL areset_pre c%0d: got {st,B,f,p}=%b, want %b",
                 c, {state, B, fault, ptr}, exp_vec());
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({state, B, fault, ptr} !== 8'b11_000_0_00) begin
      fails++;
      $display("FAIL areset_async: got st=%b B=%b f=%b p=%0d, want st=11 B=000 f=0 p=0",
               state, B, fault, ptr);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    I = 1'b0;
    S = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0);
      tests++;
      if ({state, B, fault, ptr} !== exp_vec()) begin
        fails++;
        $display("FAIL areset_post c%0d: got {st,B,f,p}=%b, want %b",
                 c, {state, B, fault, ptr}, exp_vec());
      end
      tests++;
      if (state !== ((c >= MD) ? 2'b00 : 2'b11)) begin
        fails++;
        $display("FAIL areset_dwell c%0d: got st=%b, want %b",
                 c, state, (c >= MD) ? 2'b00 : 2'b11);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_chatter();
    test_fault();
    test_stagger();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
